// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a one-byte valid/ready holding buffer.
// Reports framing errors and overruns as single-cycle pulses.
module uart_rx_monitor #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n, frame_err_n, overrun_n;
  logic          rx_meta, rx_s;
  logic          accept;

  // Idle-high reset keeps the receiver from seeing a false start bit after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  assign accept = rx_valid && rx_ready;
  assign busy   = (state != IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid && !rx_ready;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BAUD_LAST) begin
          shift_n[bit_idx] = rx_s;
          cnt_n            = '0;
          bit_idx_n        = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BAUD_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end else begin
            state_n = IDLE;
            // A byte being accepted this cycle frees the buffer for the new one.
            if (!rx_valid || accept) begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Serial receiver that sits directly downstream of the SoC's UART_TX pin.
- Decodes 8N1 frames into bytes and presents them on a valid/ready handshake with a one-byte holding buffer.
- Used both in the simulation bench (to check console output from xoro_top) and on the FPGA as a loopback/console input stage.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); must be >= 4.
- HALF_DIV, BAUD_DIV/2, cycles from start-edge detection to the start-bit mid-sample.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  holding buffer full.
- rx_ready  input  1  consumer accepts the byte on a cycle with rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the buffer was still full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (async assert, released on a clk edge): rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, bit counter=0, cycle counter=0.
- Both sync flops reset to 1.
- Synchroniser: rx passes through two flops to give rx_s. All decisions use rx_s only, so there is 2 cycles of input latency.
- IDLE: when rx_s==0, go to START and clear the cycle counter.
- START: counter increments each cycle. When counter == HALF_DIV-1:
  - rx_s==0: go to DATA, clear counter and bit index.
  - rx_s==1: treat as a glitch and return to IDLE. No pulse is generated.
- DATA: counter counts 0..BAUD_DIV-1. At BAUD_DIV-1, sample rx_s into shift[bit_index] (LSB first), clear counter, increment bit index. After bit 7 is sampled, go to STOP.
- STOP: at counter == BAUD_DIV-1, sample rx_s.
  - rx_s==1 and rx_valid==0 (or being accepted this same cycle): load rx_data, set rx_valid=1 on the next edge, go to IDLE.
  - rx_s==1 and buffer full and not accepted this cycle: drop the new byte, keep the old rx_data, pulse overrun for 1 cycle, go to IDLE.
  - rx_s==0: discard the byte, pulse frame_err for 1 cycle, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Handshake:
  - rx_valid clears on the edge after a cycle where rx_valid && rx_ready.
  - Simultaneous accept and new-byte load: the new byte wins, rx_valid stays 1, and no overrun is reported.
  - rx_data is stable while rx_valid=1.
- Latency: rx_valid rises 1 cycle after the stop-bit sample, i.e. 2 + HALF_DIV + 9*BAUD_DIV + 1 cycles after the rx falling edge (±1 for the edge phase).
- busy=1 in START, DATA, STOP and BREAK.
- Counter width is clog2(BAUD_DIV). No wrap-around beyond BAUD_DIV-1.
- Reset asserted mid-frame aborts immediately and drops any buffered byte. After release, a partial frame still in flight re-enters via IDLE; a low data bit may be mis-taken as a start bit, which is acceptable.
- No parity, single stop bit only.

Test Plan:
- BAUD_DIV=8, rx_ready=1, send frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> rx_valid pulses 1 cycle with rx_data=0xA5, frame_err=0, overrun=0, rx_valid rise about 2+4+72+1=79 cycles after the start edge.
- Glitch: rx low for 2 cycles, then high -> busy rises and falls within HALF_DIV+2 cycles, no rx_valid, no frame_err.
- Framing: send 0x3C with stop bit 0, line held low 20 cycles, then high -> one frame_err pulse, rx_valid stays 0, busy stays 1 until the line returns high.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid=1 with rx_data=0x11 held, one overrun pulse at the end of the second frame. Then rx_ready=1 for 1 cycle -> rx_valid=0.
- Back-to-back 0x00 then 0xFF with rx_ready=1, no idle gap beyond one stop bit -> two valid beats, data 0x00 then 0xFF, no errors.
- Assert reset during bit 4 of a frame, release, then send 0x5A -> all outputs 0 during reset, then a single clean byte 0x5A.
